// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 2-entry output FIFO.
// Sticky error flags and a wrapping handoff counter.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_illegal,
  output logic        err_imm,
  output logic [15:0] enc_count
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic [31:0] enc;
  logic        legal;
  logic        imm_bad;
  logic        imm12_ok;
  logic        br_ok;
  logic        jal_ok;

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        accept;
  logic        push;
  logic        pop;

  // Range checks: upper bits must be a pure sign extension.
  assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign br_ok    = ((&in_imm[31:12]) | ~(|in_imm[31:12]))
                  & ~in_imm[0];
  assign jal_ok   = ((&in_imm[31:20]) | ~(|in_imm[31:20]))
                  & ~in_imm[0];

  // Combinational encode of the presented request.
  always_comb begin
    enc     = '0;
    legal   = 1'b1;
    imm_bad = 1'b0;
    unique case (in_op)
      6'd1: enc = {7'b0000000, in_rs2, in_rs1,
                   3'b000, in_rd, OPC_R};
      6'd2: enc = {7'b0100000, in_rs2, in_rs1,
                   3'b000, in_rd, OPC_R};
      6'd3: enc = {7'b0000000, in_rs2, in_rs1,
                   3'b001, in_rd, OPC_R};
      6'd6: enc = {7'b0000000, in_rs2, in_rs1,
                   3'b111, in_rd, OPC_R};
      6'd7: enc = {7'b0000000, in_rs2, in_rs1,
                   3'b110, in_rd, OPC_R};
      6'd8: enc = {7'b0000000, in_rs2, in_rs1,
                   3'b100, in_rd, OPC_R};
      6'd11: enc = {7'b0000000, in_rs2, in_rs1,
                    3'b101, in_rd, OPC_R};
      6'd5: begin
        enc     = {in_imm[11:0], in_rs1, 3'b000,
                   in_rd, OPC_I};
        imm_bad = ~imm12_ok;
      end
      6'd12: begin
        enc     = {in_imm[11:0], in_rs1, 3'b010,
                   in_rd, OPC_LD};
        imm_bad = ~imm12_ok;
      end
      6'd13: begin
        enc     = {in_imm[11:5], in_rs2, in_rs1,
                   3'b010, in_imm[4:0], OPC_ST};
        imm_bad = ~imm12_ok;
      end
      6'd10: begin
        enc     = {in_imm[12], in_imm[10:5], in_rs2,
                   in_rs1, 3'b000, in_imm[4:1],
                   in_imm[11], OPC_BR};
        imm_bad = ~br_ok;
      end
      6'd9: begin
        enc     = {in_imm[12], in_imm[10:5], in_rs2,
                   in_rs1, 3'b100, in_imm[4:1],
                   in_imm[11], OPC_BR};
        imm_bad = ~br_ok;
      end
      6'd4: begin
        enc     = {in_imm[20], in_imm[10:1],
                   in_imm[11], in_imm[19:12],
                   in_rd, OPC_JAL};
        imm_bad = ~jal_ok;
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? mem[rd_ptr] : '0;

  assign accept = in_valid & in_ready;
  assign push   = accept & legal;
  assign pop    = out_valid & out_ready;

  // FIFO storage; contents are masked by count, so no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= enc;
    end
  end

  // FIFO pointers, occupancy, sticky flags and handoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      err_illegal <= 1'b0;
      err_imm     <= 1'b0;
      enc_count   <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (accept && !legal) begin
        err_illegal <= 1'b1;
      end
      if (push && imm_bad) begin
        err_imm <= 1'b1;
      end
      enc_count <= enc_count + {15'd0, pop};
    end
  end

endmodule
